// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM pipeline stage controller. It converts EX/MEM memory
//                control into a request/acknowledge handshake with data
//                memory, and freezes upstream stages while a request is
//                outstanding. It also registers the MEM/WB pipeline outputs,
//                inserting writeback bubbles while waiting, and aborts a
//                request with a sticky error after TIMEOUT wait cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  MEM_M,
   input  logic [1:0]  WB_M,
   input  logic [31:0] ALUOut_M,
   input  logic [31:0] WriteData_M,
   input  logic [4:0]  WriteReg_M,
   output logic        stall_M,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ack,
   output logic [1:0]  WB_W,
   output logic [31:0] ReadData_W,
   output logic [31:0] ALUOut_W,
   output logic [4:0]  WriteReg_W,
   output logic        mem_err
);

   // Reject out-of-range wait limits at elaboration; the counter is 8 bits.
   if ((TIMEOUT < 2) || (TIMEOUT > 255)) begin : g_timeout_range_check
      $error("mem_stage_ctrl: TIMEOUT must be in 2..255");
   end

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_REQ  = 1'b1
   } state_t;

   // Last REQ cycle index before the request is abandoned.
   localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

   state_t      r_state;
   logic [7:0]  r_wait_cnt;
   logic [1:0]  r_wb_w;
   logic [31:0] r_read_data_w;
   logic [31:0] r_alu_out_w;
   logic [4:0]  r_write_reg_w;
   logic        r_mem_err;

   logic        w_op;
   logic        w_in_req;
   logic        w_is_write;
   logic        w_is_read;
   logic        w_expire;
   logic        w_stall;

   // Any memory control bit set means this instruction needs the memory.
   assign w_op       = (MEM_M != 2'b00);
   assign w_in_req   = (r_state == S_REQ);
   // MemWrite dominates: a combined read/write code behaves as a plain store.
   assign w_is_write = MEM_M[0];
   assign w_is_read  = MEM_M[1] & ~MEM_M[0];
   // Final permitted wait cycle with no acknowledge: abort at this edge.
   assign w_expire   = w_in_req & ~mem_ack & (r_wait_cnt == c_WAIT_LAST);

   // Upstream freeze: raised on detection, released in the completing cycle.
   always_comb begin
      w_stall = 1'b0;
      case (r_state)
         S_IDLE:  w_stall = w_op;
         S_REQ:   w_stall = ~mem_ack & ~w_expire;
         default: w_stall = 1'b0;
      endcase
   end

   // The memory interface is driven only while a request is outstanding, so an
   // asynchronous reset drops the strobe immediately through r_state.
   assign mem_req   = w_in_req;
   assign mem_we    = w_in_req & w_is_write;
   assign mem_addr  = w_in_req ? ALUOut_M    : 32'd0;
   assign mem_wdata = w_in_req ? WriteData_M : 32'd0;

   assign stall_M    = w_stall;
   assign WB_W       = r_wb_w;
   assign ReadData_W = r_read_data_w;
   assign ALUOut_W   = r_alu_out_w;
   assign WriteReg_W = r_write_reg_w;
   assign mem_err    = r_mem_err;

   // Controller FSM with its wait counter and the MEM/WB pipeline registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_wait_cnt    <= 8'd0;
         r_wb_w        <= 2'b00;
         r_read_data_w <= 32'd0;
         r_alu_out_w   <= 32'd0;
         r_write_reg_w <= 5'd0;
         r_mem_err     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_op) begin
                  // Start a request; WB sees a bubble while it is in flight.
                  r_state    <= S_REQ;
                  r_wb_w     <= 2'b00;
                  r_wait_cnt <= 8'd0;
               end else begin
                  // Non-memory instruction passes straight through.
                  r_wb_w        <= WB_M;
                  r_alu_out_w   <= ALUOut_M;
                  r_write_reg_w <= WriteReg_M;
                  r_read_data_w <= 32'd0;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  r_state       <= S_IDLE;
                  r_wb_w        <= WB_M;
                  r_alu_out_w   <= ALUOut_M;
                  r_write_reg_w <= WriteReg_M;
                  r_read_data_w <= w_is_read ? mem_rdata : 32'd0;
               end else if (w_expire) begin
                  // Abandon the access; retire the instruction without a
                  // register write so stale data never reaches the file.
                  r_state       <= S_IDLE;
                  r_wb_w        <= {WB_M[1], 1'b0};
                  r_alu_out_w   <= ALUOut_M;
                  r_write_reg_w <= WriteReg_M;
                  r_read_data_w <= 32'd0;
                  r_mem_err     <= 1'b1;
               end else begin
                  r_wb_w     <= 2'b00;
                  r_wait_cnt <= r_wait_cnt + 8'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Directed self-checking bench for mem_stage_ctrl with a
//                short wait limit: pass-through, loads, stores, combined
//                read/write code, timeout abort and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

   localparam int c_TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  MEM_M;
   logic [1:0]  WB_M;
   logic [31:0] ALUOut_M;
   logic [31:0] WriteData_M;
   logic [4:0]  WriteReg_M;
   logic        stall_M;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [1:0]  WB_W;
   logic [31:0] ReadData_W;
   logic [31:0] ALUOut_W;
   logic [4:0]  WriteReg_W;
   logic        mem_err;

   int n_vec = 0;
   int n_err = 0;

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   mem_stage_ctrl #(.TIMEOUT(c_TIMEOUT)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .MEM_M       (MEM_M),
      .WB_M        (WB_M),
      .ALUOut_M    (ALUOut_M),
      .WriteData_M (WriteData_M),
      .WriteReg_M  (WriteReg_M),
      .stall_M     (stall_M),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata),
      .mem_ack     (mem_ack),
      .WB_W        (WB_W),
      .ReadData_W  (ReadData_W),
      .ALUOut_W    (ALUOut_W),
      .WriteReg_W  (WriteReg_W),
      .mem_err     (mem_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input logic [1:0] mem_m, input logic [1:0] wb_m,
                         input logic [31:0] alu, input logic [31:0] wd,
                         input logic [4:0] wr);
      MEM_M       = mem_m;
      WB_M        = wb_m;
      ALUOut_M    = alu;
      WriteData_M = wd;
      WriteReg_M  = wr;
   endtask

   // Called just after a falling edge with the controller idle. The ack is
   // returned on REQ cycle wait_n (0 = first REQ cycle). Returns at the
   // falling edge after the completing rising edge, with the ack removed.
   task automatic run_mem(input string name, input logic [1:0] mem_m, input logic [1:0] wb_m,
                          input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] wr,
                          input logic [31:0] rdata, input int wait_n, input logic exp_we,
                          output int stall_cnt, output int we_cnt);
      set_op(mem_m, wb_m, alu, wd, wr);
      mem_rdata = rdata;
      mem_ack   = 1'b0;
      stall_cnt = 0;
      we_cnt    = 0;
      #1;
      check({name, "_idle_req"}, 32'(mem_req), 32'd0);
      stall_cnt += int'(stall_M);
      we_cnt    += int'(mem_we);
      for (int n = 0; n <= wait_n; n++) begin
         @(negedge clk);
         mem_ack = (n == wait_n);
         #1;
         check({name, "_req"},    32'(mem_req), 32'd1);
         check({name, "_we"},     32'(mem_we),  32'(exp_we));
         check({name, "_addr"},   mem_addr,     alu);
         check({name, "_wdata"},  mem_wdata,    wd);
         check({name, "_bubble"}, 32'(WB_W),    32'd0);
         stall_cnt += int'(stall_M);
         we_cnt    += int'(mem_we);
      end
      @(negedge clk);
      mem_ack = 1'b0;
   endtask

   initial begin
      int s;
      int w;
      int req_cnt;

      rst_n = 1'b0;
      set_op(2'b00, 2'b00, 32'd0, 32'd0, 5'd0);
      mem_rdata = 32'd0;
      mem_ack   = 1'b0;

      // Reset state, before any clock edge.
      #2;
      check("rst_wb_w",    32'(WB_W),       32'd0);
      check("rst_rdata_w", ReadData_W,      32'd0);
      check("rst_alu_w",   ALUOut_W,        32'd0);
      check("rst_err",     32'(mem_err),    32'd0);
      check("rst_req",     32'(mem_req),    32'd0);
      check("rst_stall",   32'(stall_M),    32'd0);

      @(negedge clk);
      rst_n = 1'b1;

      // Non-memory instruction: one cycle through, no stall.
      set_op(2'b00, 2'b01, 32'h10, 32'd0, 5'd5);
      #1;
      check("nm_stall", 32'(stall_M), 32'd0);
      check("nm_req",   32'(mem_req), 32'd0);
      @(negedge clk);
      check("nm_wb_w",  32'(WB_W),       32'd1);
      check("nm_alu_w", ALUOut_W,        32'h10);
      check("nm_wr_w",  32'(WriteReg_W), 32'd5);
      check("nm_stall_after", 32'(stall_M), 32'd0);

      // Load, ack in the first REQ cycle.
      run_mem("ld0", 2'b10, 2'b11, 32'h100, 32'd0, 5'd7, 32'hDEADBEEF, 0, 1'b0, s, w);
      check("ld0_stall_cycles", 32'(s), 32'd1);
      check("ld0_we_cycles",    32'(w), 32'd0);
      check("ld0_rdata_w", ReadData_W,      32'hDEADBEEF);
      check("ld0_wb_w",    32'(WB_W),       32'd3);
      check("ld0_alu_w",   ALUOut_W,        32'h100);
      check("ld0_wr_w",    32'(WriteReg_W), 32'd7);
      check("ld0_req_off", 32'(mem_req),    32'd0);

      // Store, ack on the third REQ cycle.
      run_mem("st", 2'b01, 2'b10, 32'h200, 32'hA5A5A5A5, 5'd1, 32'h0BADF00D, 2, 1'b1, s, w);
      check("st_stall_cycles", 32'(s), 32'd3);
      check("st_we_cycles",    32'(w), 32'd3);
      check("st_rdata_w", ReadData_W,  32'd0);
      check("st_wb_w",    32'(WB_W),   32'd2);
      check("st_alu_w",   ALUOut_W,    32'h200);
      check("st_we_off",  32'(mem_we), 32'd0);
      check("st_wdata_off", mem_wdata, 32'd0);

      // Load with one wait cycle.
      run_mem("ld1", 2'b10, 2'b11, 32'h104, 32'd0, 5'd8, 32'h11112222, 1, 1'b0, s, w);
      check("ld1_stall_cycles", 32'(s), 32'd2);
      check("ld1_rdata_w", ReadData_W,      32'h11112222);
      check("ld1_wr_w",    32'(WriteReg_W), 32'd8);

      // Combined read/write code behaves as a store.
      run_mem("rw", 2'b11, 2'b01, 32'h300, 32'h5A5A0000, 5'd9, 32'hCAFEF00D, 0, 1'b1, s, w);
      check("rw_we_cycles", 32'(w), 32'd1);
      check("rw_rdata_w",   ReadData_W, 32'd0);
      check("rw_wb_w",      32'(WB_W),  32'd1);

      // Load to leave non-zero read data before the timeout case.
      run_mem("ld2", 2'b10, 2'b11, 32'h108, 32'd0, 5'd10, 32'h33334444, 0, 1'b0, s, w);
      check("ld2_rdata_w", ReadData_W, 32'h33334444);

      // Load that is never acknowledged.
      set_op(2'b10, 2'b11, 32'h400, 32'd0, 5'd12);
      mem_ack = 1'b0;
      #1;
      check("to_idle_stall", 32'(stall_M), 32'd1);
      req_cnt = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         #1;
         if (!mem_req) break;
         req_cnt++;
         if (req_cnt == c_TIMEOUT) check("to_last_stall", 32'(stall_M), 32'd0);
         else                      check("to_wait_stall", 32'(stall_M), 32'd1);
      end
      check("to_req_cycles", 32'(req_cnt),    32'(c_TIMEOUT));
      check("to_err",        32'(mem_err),    32'd1);
      check("to_wb_w",       32'(WB_W),       32'd2);
      check("to_rdata_w",    ReadData_W,      32'd0);
      check("to_alu_w",      ALUOut_W,        32'h400);
      check("to_wr_w",       32'(WriteReg_W), 32'd12);

      // Next op is non-memory, with a stray ack that must be ignored.
      set_op(2'b00, 2'b01, 32'h55, 32'd0, 5'd3);
      mem_ack = 1'b1;
      #1;
      check("ia_stall", 32'(stall_M), 32'd0);
      check("ia_req",   32'(mem_req), 32'd0);
      @(negedge clk);
      mem_ack = 1'b0;
      #1;
      check("ia_wb_w",   32'(WB_W),    32'd1);
      check("ia_alu_w",  ALUOut_W,     32'h55);
      check("ia_err",    32'(mem_err), 32'd1);
      check("ia_stall2", 32'(stall_M), 32'd0);

      // Asynchronous reset in the middle of a wait.
      @(negedge clk);
      set_op(2'b10, 2'b11, 32'h500, 32'd0, 5'd14);
      @(negedge clk);
      #1;
      check("ar_req_before", 32'(mem_req), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("ar_req",   32'(mem_req),    32'd0);
      check("ar_wb_w",  32'(WB_W),       32'd0);
      check("ar_err",   32'(mem_err),    32'd0);
      check("ar_alu_w", ALUOut_W,        32'd0);
      check("ar_wr_w",  32'(WriteReg_W), 32'd0);
      set_op(2'b00, 2'b01, 32'h10, 32'd0, 5'd5);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("ar_nm_stall", 32'(stall_M), 32'd0);
      @(negedge clk);
      check("ar_nm_wb_w",  32'(WB_W),       32'd1);
      check("ar_nm_alu_w", ALUOut_W,        32'h10);
      check("ar_nm_wr_w",  32'(WriteReg_W), 32'd5);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Backstop so the run always ends on its own.
   initial begin
      #100000;
      $display("FAIL watchdog: observed no completion expected completion");
      $fatal(1, "bench did not complete");
   end

endmodule
`default_nettype wire

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, meaning max REQ-state cycles awaiting mem_ack before abort (range 2..255).
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 MEM_M  input  2  memory control from EX/MEM register; bit0 MemWrite, bit1 MemRead.
REQ-005 WB_M  input  2  writeback control; bit0 RegWrite, bit1 MemtoReg.
REQ-006 ALUOut_M  input  32  ALU result, used as memory byte address.
REQ-007 WriteData_M  input  32  store data.
REQ-008 WriteReg_M  input  5  destination register number.
REQ-009 stall_M  output  1  freeze request to EX/MEM and earlier stages.
REQ-010 mem_req  output  1  data-memory request strobe.
REQ-011 mem_we  output  1  1 = write, 0 = read.
REQ-012 mem_addr  output  32  memory address.
REQ-013 mem_wdata  output  32  memory write data.
REQ-014 mem_rdata  input  32  memory read data, valid when mem_ack=1.
REQ-015 mem_ack  input  1  memory completion, one cycle per request.
REQ-016 WB_W  output  2  registered writeback control to WB stage.
REQ-017 ReadData_W  output  32  registered load data.
REQ-018 ALUOut_W  output  32  registered ALU result.
REQ-019 WriteReg_W  output  5  registered destination register.
REQ-020 mem_err  output  1  sticky timeout flag.

Function
REQ-021 FSM states: IDLE, REQ; op = MEM_M != 2'b00.
REQ-022 IDLE, op=0: stall_M=0, mem_req=0; at the edge, W registers capture WB_M, ALUOut_M, WriteReg_M; ReadData_W <= 0.
REQ-023 IDLE, op=1: stall_M=1; at the edge, go to REQ and load WB_W <= 00 (bubble); other W registers hold; wait counter cleared.
REQ-024 REQ: mem_req=1; mem_addr=ALUOut_M; mem_wdata=WriteData_M; mem_we=MEM_M[0]; upstream inputs stable (frozen by stall_M).
REQ-025 MEM_M=2'b11: write only (mem_we=1); read ignored; ReadData_W <= 0 on completion.
REQ-026 REQ, mem_ack=1: stall_M=0 in that cycle (combinational from mem_ack); at the edge, capture WB_M, ALUOut_M, WriteReg_M, and ReadData_W <= mem_rdata on a read (0 on a write); go to IDLE.
REQ-027 REQ, mem_ack=0: stall_M=1; WB_W <= 00 each edge; wait counter increments.
REQ-028 Timeout: counter reaches TIMEOUT-1 with mem_ack=0: at the edge, set mem_err=1 (sticky until reset).
REQ-028a On timeout: capture W registers with WB_W <= {WB_M[1],1'b0} (RegWrite suppressed), ReadData_W <= 0, go to IDLE.
REQ-028b On timeout: stall_M=0 in that cycle.
REQ-029 mem_ack seen in IDLE is ignored, with no state change.
REQ-030 Latency: non-memory instruction, 1 cycle through; memory op, minimum 2 cycles (IDLE detect + REQ with ack), with exactly one WB bubble per extra cycle.
REQ-031 mem_req, mem_we, mem_addr, mem_wdata: 0 outside REQ.

Reset
REQ-032 rst_n=0 forces state IDLE, wait counter 0, and all W outputs and mem_err to 0 immediately, regardless of clk.
REQ-033 Reset mid-REQ: mem_req deasserts asynchronously; the request is abandoned; the first edge after rst_n rises evaluates inputs in IDLE.

Verification
REQ-034 Non-memory op: MEM_M=00, WB_M=01, ALUOut_M=0x10, WriteReg_M=5 -> next edge WB_W=01, ALUOut_W=0x10, WriteReg_W=5, stall_M never 1.
REQ-035 Load, zero wait: MEM_M=10, ALUOut_M=0x100, WB_M=11; mem_ack=1 with rdata=0xDEADBEEF in the first REQ cycle -> stall_M high for 1 cycle, mem_req/mem_we=1/0 for 1 cycle, then ReadData_W=0xDEADBEEF, WB_W=11.
REQ-036 Store, 3-cycle ack delay: MEM_M=01, WriteData_M=0xA5A5A5A5 -> mem_we=1 held for 3 cycles, stall_M high for 3 cycles, WB_W=00 during the stall.
REQ-036a Same store: after the ack edge, ReadData_W=0.
REQ-037 Timeout with TIMEOUT=4, load, mem_ack never -> mem_req high for 4 cycles, mem_err=1, WB_W[0]=0, FSM back in IDLE; mem_err stays 1 on the next op.
REQ-038 Reset in REQ: assert rst_n=0 mid-wait -> mem_req=0 and WB_W=00 without a clock edge, mem_err=0; after release, a non-memory op passes in 1 cycle.
REQ-039 MEM_M=11 with ack -> mem_we=1, ReadData_W=0.
